fp32_reduce_ctrl: RTL and testbench

FP32_REDUCE_CTRL -- requirements
Module: fp32_reduce_ctrl

---
 rtl/fp32_reduce_ctrl.sv | 138 +++++++++++++
 tb/tb_fp32_reduce_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_reduce_ctrl.sv
// rtl/fp32_reduce_ctrl.sv - FP32 min/max reduction controller driving a shared external compare unit.
// Elements stream in one at a time; each one after the first is folded into acc through one compare round trip.
module fp32_reduce_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic             i_is_max,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             cmp_valid,
  output logic             cmp_is_max,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  input  logic             cmp_result_valid,
  input  logic [31:0]      cmp_result,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             o_busy,
  output logic             o_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FEED = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             is_max_q, is_max_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + LEN_W'(1);
  assign o_busy  = (state_q != IDLE);
  assign o_err   = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      is_max_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      is_max_q <= is_max_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    is_max_d   = is_max_q;
    err_d      = 1'b0;
    s_ready    = 1'b0;
    cmp_valid  = 1'b0;
    cmp_is_max = 1'b0;
    cmp_a      = '0;
    cmp_b      = '0;
    m_valid    = 1'b0;
    m_data     = '0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            len_d    = i_len;
            is_max_d = i_is_max;
            cnt_d    = '0;
            state_d  = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          acc_d   = s_data;
          cnt_d   = LEN_W'(1);
          state_d = (len_q == LEN_W'(1)) ? DONE : FEED;
        end
      end
      FEED: begin
        s_ready = 1'b1;
        // An aborted cycle issues no compare so no stale result can reach a later run.
        if (s_valid && !i_abort) begin
          cmp_valid  = 1'b1;
          cmp_a      = acc_q;
          cmp_b      = s_data;
          cmp_is_max = is_max_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cmp_result_valid) begin
          acc_d   = cmp_result;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? DONE : FEED;
        end
      end
      DONE: begin
        m_valid = 1'b1;
        m_data  = acc_q;
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_abort) begin
      state_d  = IDLE;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      is_max_d = is_max_q;
      err_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_fp32_reduce_ctrl.sv
// tb/tb_fp32_reduce_ctrl.sv - directed vector bench for fp32_reduce_ctrl with a behavioural compare unit.
module tb_fp32_reduce_ctrl;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             i_start = 1'b0;
  logic             i_is_max = 1'b0;
  logic [LEN_W-1:0] i_len = '0;
  logic             i_abort = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [31:0]      s_data = '0;
  logic             cmp_valid;
  logic             cmp_is_max;
  logic [31:0]      cmp_a;
  logic [31:0]      cmp_b;
  logic             cmp_result_valid = 1'b0;
  logic [31:0]      cmp_result = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [31:0]      m_data;
  logic             o_busy;
  logic             o_err;

  fp32_reduce_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn),
    .i_start(i_start), .i_is_max(i_is_max), .i_len(i_len), .i_abort(i_abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cmp_valid(cmp_valid), .cmp_is_max(cmp_is_max), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_result_valid(cmp_result_valid), .cmp_result(cmp_result),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] fcmp(input logic [31:0] a, input logic [31:0] b, input logic mx);
    logic [31:0] ka, kb;
    if (is_nan(a) || is_nan(b)) return 32'hFFFF_FFFF;
    ka = a[31] ? ~a : (a | 32'h8000_0000);
    kb = b[31] ? ~b : (b | 32'h8000_0000);
    if (mx) return (kb > ka) ? b : a;
    return (kb < ka) ? b : a;
  endfunction

  // Compare unit: registered response cmp_lat cycles after the request.
  int          cmp_lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_res = '0;
  always @(posedge clk) begin
    cmp_result_valid <= 1'b0;
    if (pend_cnt == 1) begin
      cmp_result_valid <= 1'b1;
      cmp_result       <= pend_res;
    end
    if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
    if (cmp_valid) begin
      if (cmp_lat <= 1) begin
        cmp_result_valid <= 1'b1;
        cmp_result       <= fcmp(cmp_a, cmp_b, cmp_is_max);
      end else begin
        pend_res <= fcmp(cmp_a, cmp_b, cmp_is_max);
        pend_cnt <= cmp_lat - 1;
      end
    end
  end

  typedef struct packed {
    logic            is_max;
    logic [7:0]      len;
    logic [3:0][31:0] data;
    bit              gap;
    int              lat;
    int              hold;
    bit              busy_start;
    logic [31:0]     exp;
    int              exp_cyc;
    int              exp_ncmp;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic mx, input logic [7:0] n,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input bit gap, input int lat, input int hold, input bit bs,
                              input logic [31:0] exp, input int exp_cyc, input int exp_ncmp);
    vec_t t;
    t.is_max = mx; t.len = n;
    t.data[0] = d0; t.data[1] = d1; t.data[2] = d2; t.data[3] = d3;
    t.gap = gap; t.lat = lat; t.hold = hold; t.busy_start = bs;
    t.exp = exp; t.exp_cyc = exp_cyc; t.exp_ncmp = exp_ncmp;
    return t;
  endfunction

  // Caller enters just after a rising edge with the DUT in IDLE.
  task automatic run_vec(input int v);
    vec_t        t;
    int          cyc, k, ncmp, first;
    bit          done, zero_ok, stable_ok, err_seen, hs;
    logic [31:0] held;
    t = vecs[v];
    cyc = 0; k = 0; ncmp = 0; first = -1;
    done = 0; zero_ok = 1; stable_ok = 1; err_seen = 0; held = '0;
    cmp_lat = t.lat;
    while (!done && cyc < 300) begin
      i_start  = (cyc == 0) || (t.busy_start && cyc == 2);
      i_len    = (cyc == 0) ? t.len : 8'd1;
      i_is_max = (cyc == 0) ? t.is_max : ~t.is_max;
      s_valid  = (k < int'(t.len)) && !(t.gap && (cyc % 2 == 1));
      s_data   = s_valid ? t.data[k] : 32'h0;
      m_ready  = (t.hold == 0) || (first >= 0 && (cyc - first) >= t.hold);
      @(negedge clk);
      if (cmp_valid) ncmp++;
      else if (cmp_a != 0 || cmp_b != 0 || cmp_is_max) zero_ok = 0;
      if (!m_valid && m_data != 0) zero_ok = 0;
      if (o_err) err_seen = 1;
      if (m_valid) begin
        if (first < 0) begin
          first = cyc;
          held  = m_data;
        end else if (m_data != held) begin
          stable_ok = 0;
        end
        if (m_ready) done = 1;
      end
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      if (hs) k++;
      cyc++;
    end
    i_start = 0; s_valid = 0; s_data = 0; m_ready = 0;
    chk($sformatf("v%0d_done", v), 32'(done), 32'd1);
    chk($sformatf("v%0d_data", v), held, t.exp);
    if (t.exp_cyc >= 0) chk($sformatf("v%0d_latency", v), 32'(first), 32'(t.exp_cyc));
    chk($sformatf("v%0d_ncmp", v), 32'(ncmp), 32'(t.exp_ncmp));
    chk($sformatf("v%0d_idle_zero", v), 32'(zero_ok), 32'd1);
    chk($sformatf("v%0d_stable", v), 32'(stable_ok), 32'd1);
    chk($sformatf("v%0d_no_err", v), 32'(err_seen), 32'd0);
    chk($sformatf("v%0d_idle_after", v), 32'(o_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int errs, busy_seen, mv_seen;

    vecs[0] = mk(1, 3, 32'h3F800000, 32'hC0000000, 32'h40600000, 0, 0, 1, 0, 1, 32'h40600000, 6, 2);
    vecs[1] = mk(0, 3, 32'h3F800000, 32'hC0000000, 32'h40600000, 0, 0, 1, 2, 0, 32'hC0000000, 6, 2);
    vecs[2] = mk(0, 1, 32'hBF800000, 0, 0, 0, 0, 1, 0, 0, 32'hBF800000, 2, 0);
    vecs[3] = mk(1, 2, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 4, 1);
    vecs[4] = mk(1, 4, 32'h3F800000, 32'h40000000, 32'h7FC00000, 32'h40A00000, 0, 1, 0, 0, 32'hFFFFFFFF, 8, 3);
    vecs[5] = mk(0, 4, 32'h40400000, 32'h3F800000, 32'h40000000, 32'hBF000000, 1, 3, 5, 0, 32'hBF000000, -1, 3);
    vecs[6] = mk(1, 4, 32'hC0400000, 32'hC0000000, 32'hC0800000, 32'hBF800000, 0, 1, 0, 0, 32'hBF800000, 8, 3);
    vecs[7] = mk(1, 2, 32'h40000000, 32'h40400000, 0, 0, 0, 1, 0, 0, 32'h40400000, 4, 1);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_cmp_valid", 32'(cmp_valid), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_err", 32'(o_err), 0);
    rstn = 1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) run_vec(v);

    // Zero-length start: single o_err pulse, never busy
    errs = 0; busy_seen = 0;
    i_start = 1; i_len = 0; i_is_max = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_err) errs++;
      if (o_busy) busy_seen++;
      @(posedge clk); #1;
      i_start = 0;
    end
    chk("len0_err_pulses", 32'(errs), 32'd1);
    chk("len0_busy", 32'(busy_seen), 32'd0);

    // Abort in WAIT of an N=4 run, coinciding with the compare response
    cmp_lat = 1;
    i_start = 1; i_len = 4; i_is_max = 1;
    @(posedge clk); #1;
    i_start = 0; s_valid = 1; s_data = 32'h3F800000;
    @(posedge clk); #1;
    s_data = 32'h40000000;
    @(posedge clk); #1;
    s_valid = 0; s_data = 0;
    @(negedge clk);
    chk("abort_pre_busy", 32'(o_busy), 1);
    chk("abort_pre_wait", 32'(s_ready), 0);
    i_abort = 1;
    @(posedge clk); #1;
    i_abort = 0;
    chk("abort_idle", 32'(o_busy), 0);
    mv_seen = 0; errs = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_valid || o_busy) mv_seen++;
      if (o_err) errs++;
    end
    chk("abort_no_mvalid", 32'(mv_seen), 0);
    chk("abort_no_err", 32'(errs), 0);
    @(posedge clk); #1;
    run_vec(7);

    // Reset in the middle of a run
    i_start = 1; i_len = 3; i_is_max = 1;
    @(posedge clk); #1;
    i_start = 0; s_valid = 1; s_data = 32'h40800000;
    repeat (2) @(posedge clk);
    #1;
    rstn = 0;
    #1;
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_s_ready", 32'(s_ready), 0);
    chk("midrst_m_valid", 32'(m_valid), 0);
    s_valid = 0; s_data = 0;
    @(negedge clk);
    rstn = 1;
    @(posedge clk); #1;
    run_vec(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
